alu_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one ALU_TOP instance between NUM_REQ independent requesters.
- Per operation it:
  - accepts one request (A, B, ALU_FUNC);
  - drives the ALU operand/function bus with a single-cycle Enable;
  - waits for the ALU's registered OUT_Valid;
  - returns the result to the granted requester.
- Sits between the command/register-file front-end and the ALU; it is the only driver of the ALU inputs.

---
 rtl/alu_rr_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one ALU between NUM_REQ requesters using round-robin arbitration.
//   Each operation runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//     IDLE  : choose a winner, pulse its REQ_READY bit and latch its operands.
//     ISSUE : pulse ALU_EN for one cycle with the latched operands.
//     WAIT  : hold the operands until ALU_OUT_VALID, then capture ALU_OUT.
//     RESP  : pulse RSP_VALID[grant] and move the round-robin pointer.
//
//   Optional feature: define ALU_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC cycles.
//   On a timeout the response carries RSP_ERR=1 and RSP_DATA=0. Without the
//   macro there is no counter, and RSP_ERR is tied to 0.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     per-requester request handshake (READY one-hot)
//   REQ_A/B/FUNC        packed per-requester operands and function codes
//   RSP_VALID/DATA/ERR  one-hot response strobe, result, timeout flag
//   ALU_A/B/FUNC/EN     ALU operand bus and enable
//   ALU_OUT/OUT_VALID   ALU result and its valid strobe
//   BUSY                high in every state except IDLE
module alu_rr_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int IN_DATA_WIDTH   = 8,
  parameter int Arith_OUT_WIDTH = 16,
  parameter int TIMEOUT_CYC     = 15
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_REQ-1:0]                 REQ_VALID,
  output logic [NUM_REQ-1:0]                 REQ_READY,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]   REQ_A,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]   REQ_B,
  input  logic [NUM_REQ*4-1:0]               REQ_FUNC,
  output logic [NUM_REQ-1:0]                 RSP_VALID,
  output logic [Arith_OUT_WIDTH-1:0]         RSP_DATA,
  output logic                               RSP_ERR,
  output logic [IN_DATA_WIDTH-1:0]           ALU_A,
  output logic [IN_DATA_WIDTH-1:0]           ALU_B,
  output logic [3:0]                         ALU_FUNC,
  output logic                               ALU_EN,
  input  logic [Arith_OUT_WIDTH-1:0]         ALU_OUT,
  input  logic                               ALU_OUT_VALID,
  output logic                               BUSY
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant;

  logic                     win_found;
  logic [PTR_W-1:0]         win_idx;
  logic                     found_hi;
  logic                     found_lo;
  logic [PTR_W-1:0]         idx_hi;
  logic [PTR_W-1:0]         idx_lo;
  logic [IN_DATA_WIDTH-1:0] a_sel;
  logic [IN_DATA_WIDTH-1:0] b_sel;
  logic [3:0]               f_sel;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin search: the lowest valid index above rr_ptr wins, otherwise
  // the search wraps to the lowest valid index at or below rr_ptr. The loop
  // runs downward so the last hit in each group is its lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        if (PTR_W'(i) > rr_ptr) begin
          found_hi = 1'b1;
          idx_hi   = PTR_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = PTR_W'(i);
        end
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? idx_hi : idx_lo;

    a_sel = '0;
    b_sel = '0;
    f_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win_idx) begin
        a_sel = REQ_A[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        b_sel = REQ_B[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        f_sel = REQ_FUNC[i*4 +: 4];
      end
    end
  end

  // READY is suppressed while RST is high so no request is popped on a reset edge.
  assign REQ_READY = (state == S_IDLE && !RST && win_found) ? onehot(win_idx) : '0;
  assign BUSY      = (state != S_IDLE);

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;
  assign RSP_ERR = rsp_err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      grant     <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUNC  <= '0;
      ALU_EN    <= 1'b0;
      RSP_VALID <= '0;
      RSP_DATA  <= '0;
`ifdef ALU_TIMEOUT_EN
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        // Accept stage: latch the winner and arm the one-cycle enable
        S_IDLE: begin
          if (win_found) begin
            grant    <= win_idx;
            ALU_A    <= a_sel;
            ALU_B    <= b_sel;
            ALU_FUNC <= f_sel;
            ALU_EN   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        // Issue stage: ALU_EN is high for this cycle only
        S_ISSUE: begin
          ALU_EN <= 1'b0;
`ifdef ALU_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state  <= S_WAIT;
        end
        // Wait stage: operands stay on the bus until the ALU answers
        S_WAIT: begin
          if (ALU_OUT_VALID) begin
            RSP_DATA  <= ALU_OUT;
            RSP_VALID <= onehot(grant);
`ifdef ALU_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            state     <= S_RESP;
          end
`ifdef ALU_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            RSP_DATA  <= '0;
            RSP_VALID <= onehot(grant);
            rsp_err_q <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // Response stage: single-cycle strobe, then the pointer moves
        S_RESP: begin
          RSP_VALID <= '0;
`ifdef ALU_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          rr_ptr    <= grant;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: per-requester request queues drive the
// REQ_* ports, a small ALU stub answers one cycle after ALU_EN, and a monitor
// pops expected responses from a scoreboard whenever RSP_VALID is non-zero.
module tb_alu_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int OW      = 16;
  localparam int TMO     = 15;

  logic                    CLK;
  logic                    RST;
  logic [NUM_REQ-1:0]      REQ_VALID;
  logic [NUM_REQ-1:0]      REQ_READY;
  logic [NUM_REQ*DW-1:0]   REQ_A;
  logic [NUM_REQ*DW-1:0]   REQ_B;
  logic [NUM_REQ*4-1:0]    REQ_FUNC;
  logic [NUM_REQ-1:0]      RSP_VALID;
  logic [OW-1:0]           RSP_DATA;
  logic                    RSP_ERR;
  logic [DW-1:0]           ALU_A;
  logic [DW-1:0]           ALU_B;
  logic [3:0]              ALU_FUNC;
  logic                    ALU_EN;
  logic [OW-1:0]           ALU_OUT;
  logic                    ALU_OUT_VALID;
  logic                    BUSY;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
  } req_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  req_t rq [NUM_REQ][$];
  exp_t sb [$];

  int n_vec = 0;
  int n_mis = 0;
  int rsp_cnt [NUM_REQ];
  bit alu_mute  = 1'b0;
  bit alu_force = 1'b0;

  alu_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .IN_DATA_WIDTH(DW), .Arith_OUT_WIDTH(OW), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUNC(REQ_FUNC),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  // ALU stub: 0 = add, 1 = subtract, other codes = {A,B} xor code
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      default: return {a, b} ^ {12'h000, f};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f);
    req_t r;
    r.a = a;
    r.b = b;
    r.f = f;
    rq[i].push_back(r);
  endtask

  task automatic expect_rsp(input int i, input logic [15:0] d, input logic e);
    exp_t x;
    x.idx  = 2'(i);
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) return 1'b1;
    return sb.size() != 0;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    @(negedge CLK);
    while ((BUSY !== 1'b0 || pending()) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: not drained after %0d cycles, %0d responses still expected",
               name, k, sb.size());
    end
  endtask

  task automatic wait_en(input string name, input int budget);
    int k;
    k = 0;
    @(negedge CLK);
    while (ALU_EN !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: ALU_EN not seen within %0d cycles", name, budget);
    end
  endtask

  // Requester model: holds VALID and operands of its queue head until READY.
  initial begin
    logic [NUM_REQ-1:0] rdy_s;
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_FUNC  = '0;
    forever begin
      @(negedge CLK);
      rdy_s = REQ_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdy_s[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          REQ_VALID[i]         = 1'b1;
          REQ_A[i*DW +: DW]    = rq[i][0].a;
          REQ_B[i*DW +: DW]    = rq[i][0].b;
          REQ_FUNC[i*4 +: 4]   = rq[i][0].f;
        end else begin
          REQ_VALID[i]         = 1'b0;
          REQ_A[i*DW +: DW]    = 8'hEE;
          REQ_B[i*DW +: DW]    = 8'hEE;
          REQ_FUNC[i*4 +: 4]   = 4'hE;
        end
      end
    end
  end

  // ALU stub with one cycle of latency; drives junk on ALU_OUT when not valid.
  initial begin
    logic       en_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic [3:0] f_s;
    bit         frc;
    ALU_OUT_VALID = 1'b0;
    ALU_OUT       = '0;
    forever begin
      @(negedge CLK);
      en_s = ALU_EN;
      a_s  = ALU_A;
      b_s  = ALU_B;
      f_s  = ALU_FUNC;
      frc  = alu_force;
      @(posedge CLK);
      #1;
      if (frc) begin
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'hBEEF;
      end else if (en_s === 1'b1 && !alu_mute) begin
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = alu_fn(a_s, b_s, f_s);
      end else begin
        ALU_OUT_VALID = 1'b0;
        ALU_OUT       = 16'h5A5A;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;
    forever begin
      @(negedge CLK);
      if (RSP_VALID !== '0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_rsp: RSP_VALID=%b data=%h, expected no response",
                   RSP_VALID, RSP_DATA);
        end else begin
          e = sb.pop_front();
          if (RSP_VALID !== onehot4(e.idx) || RSP_DATA !== e.data || RSP_ERR !== e.err) begin
            n_mis++;
            $display("FAIL rsp_req%0d: got valid=%b data=%h err=%b, expected valid=%b data=%h err=%b",
                     e.idx, RSP_VALID, RSP_DATA, RSP_ERR, onehot4(e.idx), e.data, e.err);
          end
          for (int i = 0; i < NUM_REQ; i++) if (RSP_VALID[i] === 1'b1) rsp_cnt[i]++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run still active at %0t, limit 300000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] a;
    logic [7:0] b;
    RST = 1'b1;

    // Fairness load: all four requesters hold five requests each while in reset.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        a = 8'(i * 16 + j);
        b = 8'(8'hF0 + i * 4);
        push_req(i, a, b, 4'd0);
        expect_rsp(i, {8'h00, a} + {8'h00, b}, 1'b0);
      end
    end

    repeat (2) begin
      @(negedge CLK);
      check("rst_ready",    32'(REQ_READY), 32'h0);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
      check("rst_alu_en",   32'(ALU_EN),    32'h0);
      check("rst_busy",     32'(BUSY),      32'h0);
      check("rst_rsp_data", 32'(RSP_DATA),  32'h0);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("first_grant", 32'(REQ_READY), 32'b0001);
    wait_drain("fairness", 400);
    for (int i = 0; i < NUM_REQ; i++) check($sformatf("fair_count%0d", i), 32'(rsp_cnt[i]), 32'd5);

    // Single operation, cycle-by-cycle.
    push_req(1, 8'd5, 8'd3, 4'b0000);
    expect_rsp(1, 16'd8, 1'b0);
    @(negedge CLK);
    check("single_c0_ready", 32'(REQ_READY), 32'b0010);
    @(negedge CLK);
    check("single_c1_en",    32'(ALU_EN),   32'h1);
    check("single_c1_a",     32'(ALU_A),    32'd5);
    check("single_c1_b",     32'(ALU_B),    32'd3);
    check("single_c1_func",  32'(ALU_FUNC), 32'h0);
    @(negedge CLK);
    check("single_c2_en",    32'(ALU_EN),   32'h0);
    check("single_c2_rsp",   32'(RSP_VALID), 32'h0);
    check("single_c2_busy",  32'(BUSY),     32'h1);
    @(negedge CLK);
    check("single_c3_rsp",   32'(RSP_VALID), 32'b0010);
    check("single_c3_data",  32'(RSP_DATA),  32'd8);
    check("single_c3_err",   32'(RSP_ERR),   32'h0);
    wait_drain("single", 50);

    // Sparse: pointer at 1 -> order 2, 3, 0. Code 4'hD is an unused code.
    push_req(2, 8'd20,  8'd7,   4'd1);
    push_req(3, 8'd200, 8'd100, 4'd0);
    push_req(0, 8'h12,  8'h34,  4'hD);
    expect_rsp(2, 16'd13,   1'b0);
    expect_rsp(3, 16'd300,  1'b0);
    expect_rsp(0, 16'h1239, 1'b0);
    wait_drain("sparse", 100);

    // Reset during WAIT; a late ALU valid must be ignored.
    alu_mute = 1'b1;
    push_req(2, 8'd1, 8'd1, 4'd0);
    wait_en("midwait_en", 50);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("midwait_busy", 32'(BUSY), 32'h1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    alu_force = 1'b1;
    @(negedge CLK);
    check("midwait_rst_data", 32'(RSP_DATA), 32'h0);
    @(posedge CLK);
    #2 alu_force = 1'b0;
    k = 0;
    repeat (5) begin
      @(negedge CLK);
      if (RSP_VALID !== '0 || BUSY !== 1'b0) k++;
    end
    check("midwait_quiet", 32'(k), 32'd0);
    alu_mute = 1'b0;
    push_req(3, 8'd9, 8'd9, 4'd0);
    push_req(0, 8'd7, 8'd1, 4'd1);
    expect_rsp(0, 16'd6,  1'b0);
    expect_rsp(3, 16'd18, 1'b0);
    wait_drain("after_reset", 100);

`ifdef ALU_TIMEOUT_EN
    // Timeout: ALU stays silent, response lands TMO cycles after WAIT entry.
    alu_mute = 1'b1;
    push_req(1, 8'd4, 8'd4, 4'd0);
    expect_rsp(1, 16'h0000, 1'b1);
    wait_en("tmo_en", 50);
    k = 0;
    while (RSP_VALID === '0 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    check("tmo_latency", 32'(k - 1), 32'(TMO));
    check("tmo_err",     32'(RSP_ERR), 32'h1);
    alu_mute = 1'b0;
    wait_drain("tmo_drain", 50);
    push_req(2, 8'd10, 8'd11, 4'd0);
    expect_rsp(2, 16'd21, 1'b0);
    wait_drain("tmo_next", 50);
`endif

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
